// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor, purely combinational: diff = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial a - b - bin, LSB first; optional signed-overflow output under SERIAL_SUB_OVF_EN.
// Result after WIDTH shift cycles plus a one-cycle done state; start ignored while busy.
module serial_subtractor4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_diff;
  logic             bit_bo;
  logic             last_bit;
  logic [WIDTH-1:0] step;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bi   (br_q),
    .diff (bit_diff),
    .bo   (bit_bo)
  );

  // Accumulated difference bits with the current bit placed on top.
  assign step     = {bit_diff, res_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    res_d  = res_q;
    d_d    = d_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      a_d   = a;
      b_d   = b;
      br_d  = bin;
      cnt_d = '0;
      res_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = bit_bo;
      cnt_d = cnt_q + CW'(1);
      res_d = step[WIDTH-1:1];
      // Outputs change only once the full result exists, never with partial bits.
      if (last_bit) begin
        d_d    = step;
        bout_d = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d  = (a_q[0] ^ b_q[0]) & (bit_diff ^ a_q[0]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// Scoreboard bench: driver pushes expected results on acceptance, monitor pops on done.
module tb_serial_subtractor4;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   cyc;

  serial_subtractor4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference for the exhaustive sweep: plain wide subtraction.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ibin, input int acc);
    exp_t m;
    logic [W:0] full;
    full   = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
    m.d    = full[W-1:0];
    m.bout = full[W];
    m.ovf  = (ia[W-1] != ib[W-1]) && (full[W-1] != ia[W-1]);
    m.acc  = acc;
    return m;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    wait_idle();
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk);
    #1;
    e.d = ed; e.bout = eb; e.ovf = eo; e.acc = cyc;
    sb_q.push_back(e);
    start = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
  endtask

  // Monitor: compares on done, checks hold between results and zero state under reset.
  initial begin
    exp_t         e;
    logic [W-1:0] last_d;
    logic         last_bout;
    last_d    = '0;
    last_bout = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_d    = '0;
        last_bout = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold: busy=%b done=%b d=%b bout=%b, expected 0 0 0000 0",
                   busy, done, d, bout);
        end
      end else if (done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: d=%b bout=%b with no operation pending", d, bout);
        end else begin
          e = sb_q.pop_front();
          if (d !== e.d || bout !== e.bout) begin
            errors++;
            $display("FAIL result: d=%b bout=%b, expected d=%b bout=%b", d, bout, e.d, e.bout);
          end
          checks++;
          if (cyc - e.acc != W) begin
            errors++;
            $display("FAIL latency: done %0d edges after accept, expected %0d", cyc - e.acc, W);
          end
`ifdef SERIAL_SUB_OVF_EN
          checks++;
          if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf: got %b, expected %b", ovf, e.ovf);
          end
`endif
          last_d    = e.d;
          last_bout = e.bout;
        end
      end else begin
        checks++;
        if (d !== last_d || bout !== last_bout) begin
          errors++;
          $display("FAIL output_hold: d=%b bout=%b, expected d=%b bout=%b",
                   d, bout, last_d, last_bout);
        end
      end
    end
  end

  initial begin
    int prev;
    int n;
    exp_t e;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: a, b, bin, expected d, bout, ovf
    issue(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    issue(4'b0001, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0);
    issue(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
    issue(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    issue(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    issue(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);
    issue(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    issue(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    issue(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0);
    issue(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);

    // start raised while busy must be ignored
    issue(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 4'b1111; b = 4'b0000; bin = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    issue(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);

    // Reset two cycles into an operation: aborted, no done
    wait_idle();
    a = 4'b0011; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 4'b0000 || bout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b d=%b bout=%b, expected 0 0 0000 0",
               busy, done, d, bout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);

    // Exhaustive sweep with start held high back-to-back
    prev  = -1;
    start = 1'b1;
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          wait_idle();
          a = W'(ia); b = W'(ib); bin = ic[0];
          @(posedge clk);
          #1;
          e = model(W'(ia), W'(ib), ic[0], cyc);
          sb_q.push_back(e);
          if (prev >= 0) begin
            checks++;
            if (cyc - prev != W + 2) begin
              errors++;
              $display("FAIL throughput: accept spacing %0d, expected %0d", cyc - prev, W + 2);
            end
          end
          prev = cyc;
          a = ~a; b = ~b; bin = ~bin;
        end
      end
    end
    start = 1'b0;

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
